// File: rtl/div_pkg.sv
// Shared types and constants for the iterative RV32M divide/remainder unit.
package div_pkg;

    localparam int XLEN_DEF = 32;
    localparam logic [XLEN_DEF-1:0] DIV_BY_ZERO_Q = {XLEN_DEF{1'b1}};
    localparam logic [XLEN_DEF-1:0] SIGNED_MIN    = {1'b1, {(XLEN_DEF-1){1'b0}}};

    // Encoding follows funct3[1:0]: bit 0 set means unsigned, bit 1 set means remainder.
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } div_state_e;

endpackage

// File: rtl/dff_ar.sv
// Enabled D flop with asynchronous active-high reset to zero.
module dff_ar #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Storage element; clears asynchronously, loads when enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= {W{1'b0}};
        end else if (en) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/div_step.sv
// One combinational radix-2 restoring division iteration on {rem, quo}.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [XLEN:0] rem_sh_s;
    logic [XLEN:0] trial_s;

    // Shift in the next dividend bit and subtract; the MSB of trial is the borrow.
    always_comb begin
        rem_sh_s = {rem, quo[XLEN-1]};
        trial_s  = rem_sh_s - {1'b0, divisor};
        if (!trial_s[XLEN]) begin
            rem_next = trial_s[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_next = rem_sh_s[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit writing back through the register file port.
module div_unit
    import div_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int REG_ENCODE_WIDTH = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [1:0]                  op,
    input  logic [XLEN-1:0]             rs1_data,
    input  logic [XLEN-1:0]             rs2_data,
    input  logic [REG_ENCODE_WIDTH-1:0] rd_addr_in,
    output logic                        busy,
    output logic                        done,
    output logic                        rd_wr_en,
    output logic [REG_ENCODE_WIDTH-1:0] rd_addr,
    output logic [XLEN-1:0]             rd_data
);

    localparam int CNT_W = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  ZERO_W   = {XLEN{1'b0}};
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(XLEN);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    div_state_e       state_r;
    div_op_e          op_r;
    logic             sgn1_r, sgn2_r;
    logic [XLEN-1:0]  rem_r, quo_r, dvs_r;
    logic [CNT_W-1:0] cnt_r;

    logic [XLEN-1:0] rem_step_s, quo_step_s;
    logic            signed_in_s, signed_r_s, early_s;
    logic [XLEN-1:0] a_mag_s, b_mag_s, early_res_s, q_fix_s, r_fix_s, final_s;

    div_step #(.XLEN(XLEN)) u_step (
        .rem      (rem_r),
        .quo      (quo_r),
        .divisor  (dvs_r),
        .rem_next (rem_step_s),
        .quo_next (quo_step_s)
    );

    // Operand magnitudes, special-case detection and final sign correction.
    always_comb begin
        signed_in_s = !op[0];
        a_mag_s     = (signed_in_s && rs1_data[XLEN-1]) ? -rs1_data : rs1_data;
        b_mag_s     = (signed_in_s && rs2_data[XLEN-1]) ? -rs2_data : rs2_data;
        early_s     = (rs2_data == ZERO_W) ||
                      (signed_in_s && (rs1_data == MIN_NEG) && (rs2_data == ALL_ONES));
        if (rs2_data == ZERO_W) begin
            early_res_s = op[1] ? rs1_data : ALL_ONES;
        end else begin
            early_res_s = op[1] ? ZERO_W : MIN_NEG;
        end
        signed_r_s = !op_r[0];
        q_fix_s    = (signed_r_s && (sgn1_r ^ sgn2_r)) ? -quo_step_s : quo_step_s;
        r_fix_s    = (signed_r_s && sgn1_r) ? -rem_step_s : rem_step_s;
        final_s    = op_r[1] ? r_fix_s : q_fix_s;
    end

    // Control FSM plus iteration datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            op_r    <= OP_DIV;
            sgn1_r  <= 1'b0;
            sgn2_r  <= 1'b0;
            rem_r   <= ZERO_W;
            quo_r   <= ZERO_W;
            dvs_r   <= ZERO_W;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        op_r   <= div_op_e'(op);
                        sgn1_r <= rs1_data[XLEN-1];
                        sgn2_r <= rs2_data[XLEN-1];
                        rem_r  <= ZERO_W;
                        quo_r  <= a_mag_s;
                        dvs_r  <= b_mag_s;
                        if (early_s) begin
                            cnt_r   <= {CNT_W{1'b0}};
                            state_r <= DONE;
                        end else begin
                            cnt_r   <= CNT_LOAD;
                            state_r <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_r <= rem_step_s;
                    quo_r <= quo_step_s;
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        state_r <= DONE;
                    end
                end
                DONE:    state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    logic                        busy_d_s, done_d_s, wr_en_d_s;
    logic [XLEN-1:0]             data_d_s;
    logic [REG_ENCODE_WIDTH-1:0] addr_d_s;

    // Next values of the registered outputs; done/data are set on the edge that enters DONE.
    always_comb begin
        busy_d_s = busy;
        done_d_s = 1'b0;
        data_d_s = rd_data;
        addr_d_s = rd_addr;
        case (state_r)
            IDLE: begin
                if (start) begin
                    busy_d_s = 1'b1;
                    addr_d_s = rd_addr_in;
                    if (early_s) begin
                        done_d_s = 1'b1;
                        data_d_s = early_res_s;
                    end else begin
                        done_d_s = 1'b0;
                    end
                end else begin
                    busy_d_s = 1'b0;
                end
            end
            CALC: begin
                if (cnt_r == CNT_ONE) begin
                    done_d_s = 1'b1;
                    data_d_s = final_s;
                end else begin
                    done_d_s = 1'b0;
                end
            end
            DONE:    busy_d_s = 1'b0;
            default: busy_d_s = 1'b0;
        endcase
        wr_en_d_s = done_d_s && (addr_d_s != {REG_ENCODE_WIDTH{1'b0}});
    end

    dff_ar #(.W(1))                u_busy_ff (.clk(clk), .rst(rst), .en(1'b1), .d(busy_d_s),  .q(busy));
    dff_ar #(.W(1))                u_done_ff (.clk(clk), .rst(rst), .en(1'b1), .d(done_d_s),  .q(done));
    dff_ar #(.W(1))                u_wren_ff (.clk(clk), .rst(rst), .en(1'b1), .d(wr_en_d_s), .q(rd_wr_en));
    dff_ar #(.W(REG_ENCODE_WIDTH)) u_addr_ff (.clk(clk), .rst(rst), .en(1'b1), .d(addr_d_s),  .q(rd_addr));
    dff_ar #(.W(XLEN))             u_data_ff (.clk(clk), .rst(rst), .en(1'b1), .d(data_d_s),  .q(rd_data));

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: arithmetic reference model plus directed jobs.
module tb_div_unit;
    import div_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs1_data = 32'h0;
    logic [31:0] rs2_data = 32'h0;
    logic [4:0]  rd_addr_in = 5'd0;
    logic        busy, done, rd_wr_en;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    div_unit #(.XLEN(32), .REG_ENCODE_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr_in(rd_addr_in),
        .busy(busy), .done(done), .rd_wr_en(rd_wr_en),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Architectural result of an RV32M divide/remainder.
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic is_rem;
        logic sgn;
        is_rem = o[1];
        sgn    = !o[0];
        if (b == 32'h0) return is_rem ? a : DIV_BY_ZERO_Q;
        if (sgn) begin
            if (a == SIGNED_MIN && b == 32'hFFFFFFFF) return is_rem ? 32'h0 : SIGNED_MIN;
            return is_rem ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
        end
        return is_rem ? a % b : a / b;
    endfunction

    function automatic logic is_early(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'h0) || (!o[0] && a == SIGNED_MIN && b == 32'hFFFFFFFF);
    endfunction

    // Reference model state: one outstanding job, expected done cycle, held result.
    logic        pending  = 1'b0;
    int          acc_cyc  = 0;
    int          done_cyc = 0;
    logic [31:0] exp_res  = 32'h0;
    logic [4:0]  exp_addr = 5'd0;
    logic [31:0] held     = 32'h0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pending  <= 1'b0;
            held     <= 32'h0;
            exp_addr <= 5'd0;
        end else if (start && !(pending && cyc <= done_cyc)) begin
            pending  <= 1'b1;
            acc_cyc  <= cyc;
            done_cyc <= cyc + (is_early(op, rs1_data, rs2_data) ? 1 : 33);
            exp_res  <= model(op, rs1_data, rs2_data);
            exp_addr <= rd_addr_in;
            if (is_early(op, rs1_data, rs2_data)) held <= model(op, rs1_data, rs2_data);
        end else if (pending && cyc + 1 == done_cyc) begin
            held <= exp_res;
        end
    end

    wire exp_busy = pending && (cyc > acc_cyc) && (cyc <= done_cyc);
    wire exp_done = pending && (cyc == done_cyc);
    wire exp_wren = exp_done && (exp_addr != 5'd0);

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Cycle-by-cycle comparison against the model, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            check("busy", {31'h0, busy}, {31'h0, exp_busy});
            check("done", {31'h0, done}, {31'h0, exp_done});
            check("rd_wr_en", {31'h0, rd_wr_en}, {31'h0, exp_wren});
            check("rd_data_held", rd_data, held);
            if (exp_done) check("rd_addr", {27'h0, rd_addr}, {27'h0, exp_addr});
        end
    end

    // Launch one job, scramble operands after accept, and wait for its done pulse.
    task automatic run_job(input string nm, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] ad, input logic [31:0] exp_lit, input int lat);
        int t0;
        int waited;
        @(negedge clk);
        op = o; rs1_data = a; rs2_data = b; rd_addr_in = ad; start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        rs1_data = $urandom;
        rs2_data = $urandom;
        waited = 0;
        while (!done && waited < 80) begin
            @(negedge clk);
            waited++;
        end
        check({nm, "_done_seen"}, {31'h0, done}, 32'h1);
        check({nm, "_latency"}, cyc - t0, lat);
        check({nm, "_data"}, rd_data, exp_lit);
        check({nm, "_wren"}, {31'h0, rd_wr_en}, {31'h0, (ad != 5'd0)});
    endtask

    initial begin
        int dones;
        int t0;
        // Pin the reference model itself to hand-computed values.
        check("pin_divu", model(2'b01, 32'd100, 32'd7), 32'h0000000E);
        check("pin_rem_neg", model(2'b10, 32'hFFFFFFEC, 32'd6), 32'hFFFFFFFE);
        check("pin_div_neg", model(2'b00, 32'hFFFFFFEC, 32'd6), 32'hFFFFFFFD);
        check("pin_div0", model(2'b00, 32'd5, 32'd0), 32'hFFFFFFFF);
        check("pin_remu0", model(2'b11, 32'd5, 32'd0), 32'h00000005);
        check("pin_ovf", model(2'b00, 32'h80000000, 32'hFFFFFFFF), 32'h80000000);
        check("pin_ovf_rem", model(2'b10, 32'h80000000, 32'hFFFFFFFF), 32'h00000000);

        repeat (3) @(negedge clk);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_wren", {31'h0, rd_wr_en}, 32'h0);
        check("rst_addr", {27'h0, rd_addr}, 32'h0);
        check("rst_data", rd_data, 32'h0);
        rst = 1'b0;

        run_job("divu_100_7", 2'b01, 32'd100, 32'd7, 5'd5, 32'h0000000E, 33);
        check("divu_100_7_addr", {27'h0, rd_addr}, 32'd5);
        run_job("rem_m20_6", 2'b10, 32'hFFFFFFEC, 32'd6, 5'd3, 32'hFFFFFFFE, 33);
        run_job("div_m20_6", 2'b00, 32'hFFFFFFEC, 32'd6, 5'd3, 32'hFFFFFFFD, 33);
        run_job("div_5_0", 2'b00, 32'd5, 32'd0, 5'd4, 32'hFFFFFFFF, 1);
        run_job("remu_5_0", 2'b11, 32'd5, 32'd0, 5'd4, 32'h00000005, 1);
        run_job("div_ovf", 2'b00, 32'h80000000, 32'hFFFFFFFF, 5'd6, 32'h80000000, 1);
        run_job("rem_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 5'd6, 32'h00000000, 1);
        run_job("div_7_m2", 2'b00, 32'd7, 32'hFFFFFFFE, 5'd8, 32'hFFFFFFFD, 33);
        run_job("rem_7_m2", 2'b10, 32'd7, 32'hFFFFFFFE, 5'd8, 32'h00000001, 33);
        run_job("rem_m7_m2", 2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 5'd9, 32'hFFFFFFFF, 33);
        run_job("div_min_2", 2'b00, 32'h80000000, 32'd2, 5'd10, 32'hC0000000, 33);
        run_job("remu_big", 2'b11, 32'hFFFFFFFF, 32'h00000010, 5'd11, 32'h0000000F, 33);
        run_job("divu_small", 2'b01, 32'd3, 32'd5, 5'd12, 32'h00000000, 33);
        run_job("divu_max_1", 2'b01, 32'hFFFFFFFF, 32'd1, 5'd0, 32'hFFFFFFFF, 33);

        // start while busy must be ignored.
        @(negedge clk);
        op = 2'b01; rs1_data = 32'd100; rs2_data = 32'd7; rd_addr_in = 5'd5; start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        op = 2'b11; rs1_data = 32'd1000; rs2_data = 32'd3; rd_addr_in = 5'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        while (!done && dones < 80) begin
            @(negedge clk);
            dones++;
        end
        check("busy_start_latency", cyc - t0, 33);
        check("busy_start_data", rd_data, 32'h0000000E);
        check("busy_start_addr", {27'h0, rd_addr}, 32'd5);
        repeat (40) @(negedge clk);

        // Reset in the middle of a calculation.
        @(negedge clk);
        op = 2'b01; rs1_data = 32'h12345678; rs2_data = 32'd3; rd_addr_in = 5'd7; start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_rst_busy", {31'h0, busy}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        check("mid_rst_data", rd_data, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("no_done_after_rst", dones, 0);
        run_job("divu_9_3", 2'b01, 32'd9, 32'd3, 5'd2, 32'h00000003, 33);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
